// File: rtl/aq_spsram_pkg.sv
// Shared definitions for the single-port SRAM sequencer/arbiter:
// FSM state encoding, requester count and byte-to-bit write-enable expansion.
package aq_spsram_pkg;

    // Number of requesters sharing the macro
    localparam int AQ_NUM_REQ = 2;

    // Sequencer states: INIT (clear sweep) and IDLE (requester traffic)
    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_IDLE = 1'b1
    } aq_state_e;

    // One active-high byte enable becomes eight active-low bit enables
    function automatic logic [7:0] be_to_wen(input logic be_bit);
        return {8{~be_bit}};
    endfunction

endpackage

// File: rtl/aq_spsram_rr_arb.sv
// Two-way round-robin grant. The grant is combinational from the valid
// vector; the pointer moves to the requester that was not served.
module aq_spsram_rr_arb
    import aq_spsram_pkg::*;
(
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_en,
    input  logic [AQ_NUM_REQ-1:0] i_vld,
    output logic [AQ_NUM_REQ-1:0] o_gnt
);

    logic                  r_ptr;
    logic [AQ_NUM_REQ-1:0] w_gnt;

    // Grant the lone valid requester, or the favoured one on contention
    always_comb begin
        w_gnt = 2'b00;
        if (i_en) begin
            case (i_vld)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = r_ptr ? 2'b10 : 2'b01;
                default: w_gnt = 2'b00;
            endcase
        end else begin
            w_gnt = 2'b00;
        end
    end

    // Pointer update: after any grant, favour the requester not granted
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ptr <= 1'b0;
        end else if (w_gnt[0]) begin
            r_ptr <= 1'b1;
        end else if (w_gnt[1]) begin
            r_ptr <= 1'b0;
        end else begin
            r_ptr <= r_ptr;
        end
    end

    assign o_gnt = w_gnt;

endmodule

// File: rtl/aq_f_spsram_arb.sv
// Sequencer and round-robin arbiter in front of a single-port SRAM macro
// with active-low CEN/GWEN/bit-WEN. Read data returns one cycle after grant.
// Optional feature macro: AQ_SPSRAM_INIT_CLR_EN -- when defined, the whole
// array is cleared to zero after every reset before any grant is issued.
module aq_f_spsram_arb
    import aq_spsram_pkg::*;
#(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req0_vld,
    input  logic                  req0_wr,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_wdata,
    input  logic [BE_WIDTH-1:0]   req0_be,
    output logic                  req0_rdy,
    output logic                  req0_rvld,
    output logic [DATA_WIDTH-1:0] req0_rdata,
    input  logic                  req1_vld,
    input  logic                  req1_wr,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_wdata,
    input  logic [BE_WIDTH-1:0]   req1_be,
    output logic                  req1_rdy,
    output logic                  req1_rvld,
    output logic [DATA_WIDTH-1:0] req1_rdata,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q,
    output logic                  init_done
);

    logic                  w_idle;
    logic                  w_arb_en;
    logic [AQ_NUM_REQ-1:0] w_vld;
    logic [AQ_NUM_REQ-1:0] w_gnt;
    logic [AQ_NUM_REQ-1:0] r_rvld;

    logic                  w_sel_wr;
    logic [ADDR_WIDTH-1:0] w_sel_addr;
    logic [DATA_WIDTH-1:0] w_sel_wdata;
    logic [BE_WIDTH-1:0]   w_sel_be;
    logic [DATA_WIDTH-1:0] w_be_wen;

    logic [ADDR_WIDTH-1:0] w_sram_a;
    logic                  w_sram_cen;
    logic                  w_sram_gwen;
    logic [DATA_WIDTH-1:0] w_sram_wen;
    logic [DATA_WIDTH-1:0] w_sram_d;

`ifdef AQ_SPSRAM_INIT_CLR_EN
    aq_state_e             r_state;
    logic [ADDR_WIDTH-1:0] r_cnt;
    logic                  r_init_done;

    // Clear-sweep sequencer: one zero write per cycle, then hand over to IDLE
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state     <= ST_INIT;
            r_cnt       <= {ADDR_WIDTH{1'b0}};
            r_init_done <= 1'b0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_cnt <= r_cnt + ADDR_WIDTH'(1);
                    if (r_cnt == {ADDR_WIDTH{1'b1}}) begin
                        r_state     <= ST_IDLE;
                        r_init_done <= 1'b1;
                    end else begin
                        r_state     <= ST_INIT;
                        r_init_done <= 1'b0;
                    end
                end
                ST_IDLE: begin
                    r_state     <= ST_IDLE;
                    r_cnt       <= r_cnt;
                    r_init_done <= 1'b1;
                end
                default: begin
                    r_state     <= ST_INIT;
                    r_cnt       <= {ADDR_WIDTH{1'b0}};
                    r_init_done <= 1'b0;
                end
            endcase
        end
    end

    assign w_idle    = (r_state == ST_IDLE);
    assign init_done = r_init_done;
`else
    assign w_idle    = 1'b1;
    assign init_done = 1'b1;
`endif

    // Reset holds both grants low combinationally, not just at the next edge
    assign w_arb_en = w_idle & ~RST;
    assign w_vld    = {req1_vld, req0_vld};

    aq_spsram_rr_arb u_rr_arb (
        .i_clk (CLK),
        .i_rst (RST),
        .i_en  (w_arb_en),
        .i_vld (w_vld),
        .o_gnt (w_gnt)
    );

    // Select the granted requester's command fields
    always_comb begin
        if (w_gnt[1]) begin
            w_sel_wr    = req1_wr;
            w_sel_addr  = req1_addr;
            w_sel_wdata = req1_wdata;
            w_sel_be    = req1_be;
        end else begin
            w_sel_wr    = req0_wr;
            w_sel_addr  = req0_addr;
            w_sel_wdata = req0_wdata;
            w_sel_be    = req0_be;
        end
    end

    for (genvar g = 0; g < BE_WIDTH; g++) begin : g_wen
        assign w_be_wen[8*g +: 8] = be_to_wen(w_sel_be[g]);
    end

    // Macro drive: clear sweep, granted access, or idle (CEN high)
    always_comb begin
        w_sram_a    = {ADDR_WIDTH{1'b0}};
        w_sram_cen  = 1'b1;
        w_sram_gwen = 1'b1;
        w_sram_wen  = {DATA_WIDTH{1'b1}};
        w_sram_d    = {DATA_WIDTH{1'b0}};
`ifdef AQ_SPSRAM_INIT_CLR_EN
        if (!RST && (r_state == ST_INIT)) begin
            w_sram_a    = r_cnt;
            w_sram_cen  = 1'b0;
            w_sram_gwen = 1'b0;
            w_sram_wen  = {DATA_WIDTH{1'b0}};
            w_sram_d    = {DATA_WIDTH{1'b0}};
        end else
`endif
        if (|w_gnt) begin
            w_sram_a    = w_sel_addr;
            w_sram_cen  = 1'b0;
            w_sram_gwen = ~w_sel_wr;
            w_sram_wen  = w_sel_wr ? w_be_wen : {DATA_WIDTH{1'b1}};
            w_sram_d    = w_sel_wdata;
        end else begin
            w_sram_cen  = 1'b1;
        end
    end

    // Read-valid pulse one cycle after a read grant; reset drops it
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rvld <= {AQ_NUM_REQ{1'b0}};
        end else begin
            r_rvld <= {w_gnt[1] & ~req1_wr, w_gnt[0] & ~req0_wr};
        end
    end

    assign req0_rdy   = w_gnt[0];
    assign req1_rdy   = w_gnt[1];
    assign req0_rvld  = r_rvld[0];
    assign req1_rvld  = r_rvld[1];
    assign req0_rdata = sram_q;
    assign req1_rdata = sram_q;

    assign sram_a    = w_sram_a;
    assign sram_cen  = w_sram_cen;
    assign sram_gwen = w_sram_gwen;
    assign sram_wen  = w_sram_wen;
    assign sram_d    = w_sram_d;

endmodule

// File: tb/tb_aq_f_spsram_arb.sv
// Scoreboard bench for aq_f_spsram_arb: stimulus pushes expected grants,
// a monitor pops them on rdy and checks read data on rvld.
`timescale 1ns/1ps
module tb_aq_f_spsram_arb;

    logic        CLK = 1'b0;
    logic        RST;
    logic        req0_vld, req0_wr, req1_vld, req1_wr;
    logic [10:0] req0_addr, req1_addr;
    logic [31:0] req0_wdata, req1_wdata;
    logic [3:0]  req0_be, req1_be;
    logic        req0_rdy, req0_rvld, req1_rdy, req1_rvld;
    logic [31:0] req0_rdata, req1_rdata;
    logic [10:0] sram_a;
    logic        sram_cen, sram_gwen, init_done;
    logic [31:0] sram_wen, sram_d, sram_q;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    typedef struct {
        int          req;
        logic        wr;
        logic [10:0] addr;
        logic [31:0] wen;
        logic [31:0] d;
        logic [31:0] rdata;
    } gexp_t;

    typedef struct {
        int          req;
        logic [31:0] rdata;
        int          due;
    } rexp_t;

    gexp_t gq[$];
    rexp_t rq[$];
    logic [31:0] mem [0:2047];

    aq_f_spsram_arb dut (
        .CLK(CLK), .RST(RST),
        .req0_vld(req0_vld), .req0_wr(req0_wr), .req0_addr(req0_addr),
        .req0_wdata(req0_wdata), .req0_be(req0_be), .req0_rdy(req0_rdy),
        .req0_rvld(req0_rvld), .req0_rdata(req0_rdata),
        .req1_vld(req1_vld), .req1_wr(req1_wr), .req1_addr(req1_addr),
        .req1_wdata(req1_wdata), .req1_be(req1_be), .req1_rdy(req1_rdy),
        .req1_rvld(req1_rvld), .req1_rdata(req1_rdata),
        .sram_a(sram_a), .sram_cen(sram_cen), .sram_gwen(sram_gwen),
        .sram_wen(sram_wen), .sram_d(sram_d), .sram_q(sram_q),
        .init_done(init_done)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) cyc <= cyc + 1;

    // Behavioural SRAM macro: masked write, registered read
    always @(posedge CLK) begin
        if (sram_cen === 1'b0) begin
            if (sram_gwen === 1'b0)
                mem[sram_a] <= (mem[sram_a] & sram_wen) | (sram_d & ~sram_wen);
            else
                sram_q <= mem[sram_a];
        end
    end

    function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    function automatic void push(input int r, input logic wr, input logic [10:0] a,
                                 input logic [31:0] d, input logic [31:0] wen, input logic [31:0] rd);
        gexp_t g;
        g.req = r; g.wr = wr; g.addr = a; g.d = d; g.wen = wen; g.rdata = rd;
        gq.push_back(g);
    endfunction

    task automatic set_req(input int r, input logic v, input logic wr, input logic [10:0] a,
                           input logic [31:0] wd, input logic [3:0] be);
        if (r == 0) begin
            req0_vld = v; req0_wr = wr; req0_addr = a; req0_wdata = wd; req0_be = be;
        end else begin
            req1_vld = v; req1_wr = wr; req1_addr = a; req1_wdata = wd; req1_be = be;
        end
    endtask

    // Hold the request until granted (bounded), then release after the edge
    task automatic drive(input int r, input logic wr, input logic [10:0] a,
                         input logic [31:0] wd, input logic [3:0] be, output int waited);
        int n;
        n = 0;
        set_req(r, 1'b1, wr, a, wd, be);
        @(negedge CLK);
        while (!(r == 0 ? req0_rdy : req1_rdy) && n < 100) begin
            n++;
            @(negedge CLK);
        end
        if (n >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL rdy_timeout: requester %0d never granted", r);
        end
        waited = n;
        @(posedge CLK);
        #1;
        set_req(r, 1'b0, wr, a, wd, be);
    endtask

    // Monitor: check every grant and every read response against the queues
    always @(negedge CLK) begin
        gexp_t g;
        rexp_t re;
        if (RST === 1'b0) begin
            if (req0_rvld === 1'b1 || req1_rvld === 1'b1) begin
                if (rq.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL rvld_unexpected: rvld0=%b rvld1=%b", req0_rvld, req1_rvld);
                end else begin
                    re = rq.pop_front();
                    check("rvld_both", {31'd0, req0_rvld & req1_rvld}, 32'd0);
                    check("rvld_req", req1_rvld ? 32'd1 : 32'd0, 32'(re.req));
                    check("rvld_latency", 32'(cyc), 32'(re.due));
                    check("rdata", req1_rvld ? req1_rdata : req0_rdata, re.rdata);
                end
            end else if (rq.size() != 0 && rq[0].due <= cyc) begin
                re = rq.pop_front();
                n_tests++; n_fail++;
                $display("FAIL rvld_missing: got none expected rvld for req%0d at cycle %0d", re.req, re.due);
            end
            if (req0_rdy === 1'b1 || req1_rdy === 1'b1) begin
                if (gq.size() == 0) begin
                    n_tests++; n_fail++;
                    $display("FAIL grant_unexpected: rdy0=%b rdy1=%b", req0_rdy, req1_rdy);
                end else begin
                    g = gq.pop_front();
                    check("grant_both", {31'd0, req0_rdy & req1_rdy}, 32'd0);
                    check("grant_req", req1_rdy ? 32'd1 : 32'd0, 32'(g.req));
                    check("sram_cen", {31'd0, sram_cen}, 32'd0);
                    check("sram_a", {21'd0, sram_a}, {21'd0, g.addr});
                    check("sram_gwen", {31'd0, sram_gwen}, {31'd0, ~g.wr});
                    check("sram_wen", sram_wen, g.wen);
                    check("sram_d", sram_d, g.d);
                    if (!g.wr) begin
                        re.req = g.req; re.rdata = g.rdata; re.due = cyc + 1;
                        rq.push_back(re);
                    end
                end
            end
        end
    end

`ifdef AQ_SPSRAM_INIT_CLR_EN
    // Watch n sweep cycles: zero write to address i, no grant, init_done low
    task automatic sweep_check(input int n);
        int bad, busy;
        bad = 0; busy = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            if (sram_a !== 11'(i) || sram_cen !== 1'b0 || sram_gwen !== 1'b0 ||
                sram_wen !== 32'h0 || sram_d !== 32'h0) bad++;
            if (init_done !== 1'b0 || req0_rdy !== 1'b0 || req1_rdy !== 1'b0) busy++;
        end
        check("init_sweep_bad_cycles", 32'(bad), 32'd0);
        check("init_busy_cycles", 32'(busy), 32'd0);
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int w, c0;
`ifdef AQ_SPSRAM_INIT_CLR_EN
        for (int i = 0; i < 2048; i++) mem[i] = 32'hDEAD_BEEF;
`else
        for (int i = 0; i < 2048; i++) mem[i] = 32'h0;
`endif
        sram_q = 32'h0;
        RST = 1'b1;
        set_req(0, 1'b1, 1'b0, 11'h7FF, 32'h0, 4'h0);
        set_req(1, 1'b1, 1'b0, 11'h001, 32'h0, 4'h0);

        // Reset state with both requesters asking
        @(posedge CLK);
        @(negedge CLK);
        check("rst_rdy0", {31'd0, req0_rdy}, 32'd0);
        check("rst_rdy1", {31'd0, req1_rdy}, 32'd0);
        check("rst_rvld", {30'd0, req1_rvld, req0_rvld}, 32'd0);
        check("rst_cen", {31'd0, sram_cen}, 32'd1);
        check("rst_gwen", {31'd0, sram_gwen}, 32'd1);
        check("rst_wen", sram_wen, 32'hFFFF_FFFF);
        @(posedge CLK);
        #1;
        RST = 1'b0;
        req1_vld = 1'b0;

        // First access: read 0x7FF (zero in a cleared / zero-modelled array)
        push(0, 1'b0, 11'h7FF, 32'h0, 32'hFFFF_FFFF, 32'h0000_0000);
`ifdef AQ_SPSRAM_INIT_CLR_EN
        check("init_done_low", {31'd0, init_done}, 32'd0);
        sweep_check(1000);
        @(posedge CLK);
        #1;
        RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        sweep_check(2048);
`else
        check("init_done_tied", {31'd0, init_done}, 32'd1);
`endif
        drive(0, 1'b0, 11'h7FF, 32'h0, 4'h0, w);
        check("first_grant_wait", 32'(w), 32'd0);
        check("init_done_high", {31'd0, init_done}, 32'd1);

        // Byte write then read on req0
        push(0, 1'b1, 11'h123, 32'hAABB_CCDD, 32'hFF00_FF00, 32'h0);
        push(0, 1'b0, 11'h123, 32'h0, 32'hFFFF_FFFF, 32'h00BB_00DD);
        drive(0, 1'b1, 11'h123, 32'hAABB_CCDD, 4'b0101, w);
        drive(0, 1'b0, 11'h123, 32'h0, 4'h0, w);

        // be = 0 write leaves the word unchanged
        push(0, 1'b1, 11'h005, 32'h1234_5678, 32'h0000_0000, 32'h0);
        push(0, 1'b1, 11'h005, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);
        push(0, 1'b0, 11'h005, 32'h0, 32'hFFFF_FFFF, 32'h1234_5678);
        drive(0, 1'b1, 11'h005, 32'h1234_5678, 4'hF, w);
        drive(0, 1'b1, 11'h005, 32'hFFFF_FFFF, 4'h0, w);
        drive(0, 1'b0, 11'h005, 32'h0, 4'h0, w);

        // req1 preload then streaming reads of 0..7
        for (int k = 0; k < 8; k++)
            push(1, 1'b1, 11'(k), 32'hC0DE_0000 + 32'(k), 32'h0000_0000, 32'h0);
        for (int k = 0; k < 8; k++)
            drive(1, 1'b1, 11'(k), 32'hC0DE_0000 + 32'(k), 4'hF, w);
        for (int k = 0; k < 8; k++)
            push(1, 1'b0, 11'(k), 32'h0, 32'hFFFF_FFFF, 32'hC0DE_0000 + 32'(k));
        c0 = cyc;
        for (int k = 0; k < 8; k++)
            drive(1, 1'b0, 11'(k), 32'h0, 4'h0, w);
        check("stream_cycles", 32'(cyc - c0), 32'd8);

        // Contention: both valid for four cycles, alternate starting with req0
        push(0, 1'b0, 11'd1, 32'h0, 32'hFFFF_FFFF, 32'hC0DE_0001);
        push(1, 1'b0, 11'd3, 32'h0, 32'hFFFF_FFFF, 32'hC0DE_0003);
        push(0, 1'b0, 11'd2, 32'h0, 32'hFFFF_FFFF, 32'hC0DE_0002);
        push(1, 1'b0, 11'd4, 32'h0, 32'hFFFF_FFFF, 32'hC0DE_0004);
        c0 = cyc;
        fork
            begin
                int w0;
                drive(0, 1'b0, 11'd1, 32'h0, 4'h0, w0);
                drive(0, 1'b0, 11'd2, 32'h0, 4'h0, w0);
            end
            begin
                int w1;
                drive(1, 1'b0, 11'd3, 32'h0, 4'h0, w1);
                drive(1, 1'b0, 11'd4, 32'h0, 4'h0, w1);
            end
        join
        check("contend_cycles", 32'(cyc - c0), 32'd4);

        repeat (3) @(negedge CLK);
        check("grants_left", 32'(gq.size()), 32'd0);
        check("reads_left", 32'(rq.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
